delay_line_taps: RTL and testbench

- Multi-tap, runtime-configurable sample delay line for the stream-filter pipeline.
- Emits NUM_TAPS samples per accepted input: the current sample plus copies delayed by 1..NUM_TAPS-1 times cfg_delay accepted samples.
- Serves as the line buffer feeding 2D/vertical filter kernels; cfg_delay is set to the image line length.
- Generalises the single-tap delay memory with tap count, ready/valid backpressure, delay clamping and a fill state machine.

---
 rtl/delay_line_taps.sv | 116 +++++++++++
 tb/tb_delay_line_taps.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/delay_line_taps.sv
// Multi-tap sample delay line: tap k carries the sample accepted k*delay samples earlier.
// Optional build macro DELAY_LINE_TAPS_ZERO_FILL_EN: emit words during FILL with unfilled taps zeroed.
module delay_line_taps #(
  parameter int IMG_WIDTH  = 8,
  parameter int MEM_AWIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int NUM_TAPS   = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [MEM_AWIDTH-1:0]           cfg_delay,
  input  logic                            cfg_set,
  input  logic [IMG_WIDTH-1:0]            up_data,
  input  logic                            up_val,
  output logic                            up_rdy,
  output logic [IMG_WIDTH*NUM_TAPS-1:0]   dn_data,
  output logic                            dn_val,
  input  logic                            dn_rdy
);

  localparam int DW = MEM_AWIDTH + 1;
  localparam int FW = MEM_AWIDTH + $clog2(NUM_TAPS);
  localparam int NR = NUM_TAPS - 1;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t                 state;
  logic [DW-1:0]          delay;
  logic [MEM_AWIDTH-1:0]  ptr;
  logic [FW-1:0]          fill_cnt;

  logic [IMG_WIDTH-1:0]   mem [NR][MEM_DEPTH];
  logic [IMG_WIDTH-1:0]   rd  [NR];
  logic [IMG_WIDTH-1:0]   tap [NUM_TAPS];
  logic [IMG_WIDTH*NUM_TAPS-1:0] tap_word;
  logic [DW-1:0]          cfg_clamped;
  logic [FW-1:0]          fill_target;
  logic                   xfer;
  logic                   emit;

  always_comb begin
    cfg_clamped = {1'b0, cfg_delay};
    if (cfg_delay == '0)
      cfg_clamped = DW'(1);
    else if ({1'b0, cfg_delay} > DW'(MEM_DEPTH))
      cfg_clamped = DW'(MEM_DEPTH);
  end

  always_comb begin
    fill_target = FW'(NR) * FW'(delay);
    up_rdy      = (state != IDLE) && !cfg_set && (!dn_val || dn_rdy);
    xfer        = up_val && up_rdy;
`ifdef DELAY_LINE_TAPS_ZERO_FILL_EN
    emit        = xfer;
`else
    emit        = xfer && (state == RUN);
`endif
  end

  // RAM k holds the samples that tap k+1 will present once the pointer comes around.
  always_comb begin
    tap[0] = up_data;
    for (int unsigned k = 0; k < NR; k++) begin
      rd[k]     = mem[k][ptr];
      tap[k+1]  = rd[k];
    end
`ifdef DELAY_LINE_TAPS_ZERO_FILL_EN
    for (int unsigned k = 1; k < NUM_TAPS; k++)
      if (fill_cnt < FW'(k) * FW'(delay))
        tap[k] = '0;
`endif
    tap_word = '0;
    for (int unsigned k = 0; k < NUM_TAPS; k++)
      tap_word[k*IMG_WIDTH +: IMG_WIDTH] = tap[k];
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      mem[0][ptr] <= up_data;
      for (int unsigned k = 1; k < NR; k++)
        mem[k][ptr] <= rd[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dn_val   <= 1'b0;
      dn_data  <= '0;
      delay    <= DW'(1);
      ptr      <= '0;
      fill_cnt <= '0;
    end else if (cfg_set) begin
      state    <= FILL;
      delay    <= cfg_clamped;
      ptr      <= '0;
      fill_cnt <= '0;
      dn_val   <= 1'b0;
    end else begin
      if (xfer) begin
        ptr <= ({1'b0, ptr} == delay - DW'(1)) ? '0 : ptr + MEM_AWIDTH'(1);
        if (fill_cnt != fill_target)
          fill_cnt <= fill_cnt + FW'(1);
        if (state == FILL && fill_cnt + FW'(1) == fill_target)
          state <= RUN;
      end
      if (emit) begin
        dn_val  <= 1'b1;
        dn_data <= tap_word;
      end else if (dn_rdy) begin
        dn_val  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_delay_line_taps.sv
// Scoreboard bench for delay_line_taps: a sample-history model predicts every output word.
module tb_delay_line_taps;

  localparam int W = 8;
  localparam int T = 3;
`ifdef DELAY_LINE_TAPS_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [7:0]     cfg_delay;
  logic           cfg_set;
  logic [W-1:0]   up_data;
  logic           up_val;
  logic           up_rdy;
  logic [W*T-1:0] dn_data;
  logic           dn_val;
  logic           dn_rdy;

  logic [7:0]     cfg2_delay;
  logic           cfg2_set;
  logic [W-1:0]   u2_data;
  logic           u2_val;
  logic           u2_rdy;
  logic [W*T-1:0] d2_data;
  logic           d2_val;

  always #5 clk = ~clk;

  delay_line_taps #(.IMG_WIDTH(W), .MEM_AWIDTH(8), .MEM_DEPTH(256), .NUM_TAPS(T)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_delay(cfg_delay), .cfg_set(cfg_set),
    .up_data(up_data), .up_val(up_val), .up_rdy(up_rdy),
    .dn_data(dn_data), .dn_val(dn_val), .dn_rdy(dn_rdy)
  );

  delay_line_taps #(.IMG_WIDTH(W), .MEM_AWIDTH(8), .MEM_DEPTH(200), .NUM_TAPS(T)) u_dut_clamp (
    .clk(clk), .rst_n(rst_n), .cfg_delay(cfg2_delay), .cfg_set(cfg2_set),
    .up_data(u2_data), .up_val(u2_val), .up_rdy(u2_rdy),
    .dn_data(d2_data), .dn_val(d2_val), .dn_rdy(1'b1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int nout     = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Model state: 0 idle, 1 fill, 2 run
  int             ms, md, n, idx;
  logic           mv, newword, exp_rdy, xf;
  logic [W*T-1:0] held, w;
  logic [W*T-1:0] sb [$];
  logic [W-1:0]   hist [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      ms = 0; md = 1; mv = 1'b0; newword = 1'b0;
      hist.delete(); sb.delete();
    end else begin
      exp_rdy = (ms != 0) && !cfg_set && (!mv || dn_rdy);
      check("dn_val", dn_val, mv);
      check("up_rdy", up_rdy, exp_rdy);
      if (newword) begin
        if (sb.size() == 0) check("sb_size", sb.size(), 1);
        else begin
          held = sb.pop_front();
          check("dn_data", dn_data, held);
          nout++;
        end
      end else if (mv) begin
        check("dn_hold", dn_data, held);
      end
      newword = 1'b0;
      xf = up_val && exp_rdy;
      if (cfg_set) begin
        ms = 1;
        md = (cfg_delay == 0) ? 1 : int'(cfg_delay);
        hist.delete();
        mv = 1'b0;
      end else if (xf) begin
        hist.push_back(up_data);
        n = hist.size();
        if (ms == 2 || ZF) begin
          for (int k = 0; k < T; k++) begin
            idx = n - 1 - k * md;
            w[k*W +: W] = (idx >= 0) ? hist[idx] : '0;
          end
          sb.push_back(w);
          mv = 1'b1;
          newword = 1'b1;
        end else if (dn_rdy) begin
          mv = 1'b0;
        end
        if (ms == 1 && n == (T - 1) * md) ms = 2;
      end else if (mv && dn_rdy) begin
        mv = 1'b0;
      end
    end
  end

  task automatic idle(input int cyc);
    repeat (cyc) begin @(posedge clk); #1; end
  endtask

  task automatic do_cfg(input logic [7:0] d);
    cfg_delay = d;
    cfg_set   = 1'b1;
    @(posedge clk); #1;
    cfg_set   = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] v, input int gap);
    int waited;
    waited  = 0;
    up_val  = 1'b1;
    up_data = v;
    @(negedge clk);
    while (!up_rdy && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!up_rdy) check("up_rdy_wait", up_rdy, 1);
    @(posedge clk); #1;
    up_val = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic stream(input int first, input int cnt, input int gap);
    for (int i = 0; i < cnt; i++) send(8'(first + i), gap);
  endtask

  int early;

  initial begin
    rst_n = 1'b0; cfg_delay = '0; cfg_set = 1'b0; up_data = '0; up_val = 1'b0; dn_rdy = 1'b1;
    cfg2_delay = '0; cfg2_set = 1'b0; u2_data = '0; u2_val = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dn_val", dn_val, 0);
    check("rst_dn_data", dn_data, 0);
    check("rst_up_rdy", up_rdy, 0);
    rst_n = 1'b1;
    idle(2);

    // Continuous stream, delay 10
    nout = 0; do_cfg(8'd10); stream(1, 30, 0); idle(3);
    check("cont_count", nout, ZF ? 30 : 10);
    check("cont_last", held, {8'd10, 8'd20, 8'd30});

    // Alternating valid gaps
    nout = 0; do_cfg(8'd10); stream(1, 30, 1); idle(3);
    check("gap_count", nout, ZF ? 30 : 10);

    // Downstream stall of 4 cycles in RUN
    nout = 0; do_cfg(8'd10);
    fork
      stream(1, 30, 0);
      begin
        repeat (24) @(posedge clk);
        #1 dn_rdy = 1'b0;
        repeat (4) @(posedge clk);
        #1 dn_rdy = 1'b1;
      end
    join
    idle(3);
    check("stall_count", nout, ZF ? 30 : 10);

    // Zero delay clamps to 1
    nout = 0; do_cfg(8'd0); stream(1, 5, 0); idle(3);
    check("clamp0_count", nout, ZF ? 5 : 3);
    check("clamp0_last", held, {8'd3, 8'd4, 8'd5});

    // Reconfigure mid-stream: delay 10 then delay 4
    nout = 0; do_cfg(8'd10); stream(1, 25, 0);
    do_cfg(8'd4); stream(101, 12, 0); idle(3);
    check("recfg_count", nout, ZF ? 37 : 9);
    check("recfg_last", held, {8'd104, 8'd108, 8'd112});

    // Async reset mid-RUN
    nout = 0; do_cfg(8'd10); stream(1, 23, 0);
    check("prerst_count", nout, ZF ? 22 : 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dn_val", dn_val, 0);
    check("arst_dn_data", dn_data, 0);
    check("arst_up_rdy", up_rdy, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    nout = 0; up_val = 1'b1; up_data = 8'd7;
    idle(5);
    up_val = 1'b0;
    check("postrst_count", nout, 0);
    check("postrst_dn_val", dn_val, 0);

    // Zero-fill scenario (no output at all in the default build)
    nout = 0; do_cfg(8'd2); stream(1, 3, 0); idle(3);
    check("zf_count", nout, ZF ? 3 : 0);

    // Upper clamp on a 200-deep instance
    early = 0;
    cfg2_delay = 8'd255; cfg2_set = 1'b1;
    @(posedge clk); #1;
    cfg2_set = 1'b0;
    for (int i = 1; i <= 401; i++) begin
      u2_data = i[7:0];
      u2_val  = 1'b1;
      @(negedge clk);
      if (!u2_rdy) check("u2_rdy", u2_rdy, 1);
      @(posedge clk); #1;
      if (i < 401 && d2_val) early++;
    end
    u2_val = 1'b0;
    check("clamp_early", early, ZF ? 400 : 0);
    check("clamp_val", d2_val, 1);
    check("clamp_data", d2_data, {8'd1, 8'd201, 8'd145});
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
